// File: rtl/pla_eval_pipe.sv
// Runtime-programmable two-level PLA evaluator behind a 2-stage valid/ready pipeline.
// AND-plane cubes, OR-plane rows and output polarity are written over a config port while the pipe is empty.
module pla_eval_pipe #(
    parameter int          N_IN       = 16,
    parameter int          N_OUT      = 46,
    parameter int          N_TERMS    = 64,
    parameter int          CW         = (N_IN > N_OUT) ? N_IN : N_OUT,
    parameter logic [15:0] CNT_PRESET = 16'h0000,
    localparam int         AW         = $clog2(N_TERMS)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             cfg_we_i,
    input  logic [1:0]       cfg_sel_i,
    input  logic [AW-1:0]    cfg_addr_i,
    input  logic [CW-1:0]    cfg_wdata_i,
    output logic             cfg_ready_o,
    output logic             cfg_err_o,
    input  logic             cfg_err_clr_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [N_IN-1:0]  in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [N_OUT-1:0] out_data_o,
    output logic [15:0]      eval_cnt_o
);

    logic [N_IN-1:0]    care_q  [N_TERMS];
    logic [N_IN-1:0]    value_q [N_TERMS];
    logic [N_OUT-1:0]   orrow_q [N_TERMS];
    logic [N_OUT-1:0]   pol_q;

    logic               s1_valid_q;
    logic [N_TERMS-1:0] term_q;
    logic [N_TERMS-1:0] term_d;

    logic               s2_valid_q;
    logic [N_OUT-1:0]   out_q;
    logic [N_OUT-1:0]   out_d;

    logic               cfg_err_q;
    logic [15:0]        cnt_q;

    logic               s1_accept;
    logic               s2_accept;
    logic               in_fire;
    logic               out_fire;
    logic               cfg_wr_en;
    logic               cfg_bad;

    assign s2_accept   = !s2_valid_q || out_ready_i;
    assign s1_accept   = !s1_valid_q || s2_accept;
    assign in_ready_o  = s1_accept && !cfg_we_i;
    assign in_fire     = in_valid_i && in_ready_o;
    assign out_fire    = s2_valid_q && out_ready_i;

    assign cfg_ready_o = !s1_valid_q && !s2_valid_q;
    assign cfg_wr_en   = cfg_we_i && cfg_ready_o;
    assign cfg_bad     = cfg_we_i && !cfg_ready_o;

    assign out_valid_o = s2_valid_q;
    assign out_data_o  = out_q;
    assign cfg_err_o   = cfg_err_q;
    assign eval_cnt_o  = cnt_q;

    // Config writes only land while the pipe is empty, so every vector sees one consistent plane set.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int t = 0; t < N_TERMS; t++) begin
                care_q[t]  <= '0;
                value_q[t] <= '0;
                orrow_q[t] <= '0;
            end
            pol_q <= '0;
        end else if (cfg_wr_en) begin
            case (cfg_sel_i)
                2'd0:    care_q[cfg_addr_i]  <= cfg_wdata_i[N_IN-1:0];
                2'd1:    value_q[cfg_addr_i] <= cfg_wdata_i[N_IN-1:0];
                2'd2:    orrow_q[cfg_addr_i] <= cfg_wdata_i[N_OUT-1:0];
                default: pol_q               <= cfg_wdata_i[N_OUT-1:0];
            endcase
        end
    end

    // A term matches when no cared-about input bit differs from its cube value.
    always_comb begin
        term_d = '0;
        for (int t = 0; t < N_TERMS; t++) begin
            term_d[t] = ~|(care_q[t] & (in_data_i ^ value_q[t]));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid_q <= 1'b0;
            term_q     <= '0;
        end else if (s1_accept) begin
            s1_valid_q <= in_fire;
            if (in_fire) begin
                term_q <= term_d;
            end
        end
    end

    always_comb begin
        out_d = '0;
        for (int t = 0; t < N_TERMS; t++) begin
            if (term_q[t]) begin
                out_d = out_d | orrow_q[t];
            end
        end
        out_d = out_d ^ pol_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s2_valid_q <= 1'b0;
            out_q      <= '0;
        end else if (s2_accept) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_q <= out_d;
            end
        end
    end

    // A rejected write wins over a simultaneous clear so no error is silently lost.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cfg_err_q <= 1'b0;
        end else if (cfg_bad) begin
            cfg_err_q <= 1'b1;
        end else if (cfg_err_clr_i) begin
            cfg_err_q <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= CNT_PRESET;
        end else if (out_fire && (cnt_q != 16'hFFFF)) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

endmodule

// File: tb/tb_pla_eval_pipe.sv
// Self-checking bench for pla_eval_pipe: a spec-level PLA/occupancy model checked every cycle,
// plus directed vectors with hand-computed results.
module tb_pla_eval_pipe;

    logic        clk;
    logic        rst_n;
    logic        cfg_we;
    logic [1:0]  cfg_sel;
    logic [5:0]  cfg_addr;
    logic [45:0] cfg_wdata;
    logic        cfg_err_clr;
    logic        in_valid;
    logic [15:0] in_data;
    logic        out_ready;

    logic        cfg_ready;
    logic        cfg_err;
    logic        in_ready;
    logic        out_valid;
    logic [45:0] out_data;
    logic [15:0] eval_cnt;

    logic        cfg_ready2;
    logic        cfg_err2;
    logic        in_ready2;
    logic        out_valid2;
    logic [45:0] out_data2;
    logic [15:0] eval_cnt2;

    int checks   = 0;
    int failures = 0;

    pla_eval_pipe dut (
        .clk_i(clk), .rst_ni(rst_n), .cfg_we_i(cfg_we), .cfg_sel_i(cfg_sel),
        .cfg_addr_i(cfg_addr), .cfg_wdata_i(cfg_wdata), .cfg_ready_o(cfg_ready),
        .cfg_err_o(cfg_err), .cfg_err_clr_i(cfg_err_clr), .in_valid_i(in_valid),
        .in_ready_o(in_ready), .in_data_i(in_data), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .out_data_o(out_data), .eval_cnt_o(eval_cnt)
    );

    pla_eval_pipe #(.CNT_PRESET(16'hFFFE)) dutSat (
        .clk_i(clk), .rst_ni(rst_n), .cfg_we_i(cfg_we), .cfg_sel_i(cfg_sel),
        .cfg_addr_i(cfg_addr), .cfg_wdata_i(cfg_wdata), .cfg_ready_o(cfg_ready2),
        .cfg_err_o(cfg_err2), .cfg_err_clr_i(cfg_err_clr), .in_valid_i(in_valid),
        .in_ready_o(in_ready2), .in_data_i(in_data), .out_valid_o(out_valid2),
        .out_ready_i(out_ready), .out_data_o(out_data2), .eval_cnt_o(eval_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Behavioural model: plane contents, in-flight results with their visibility cycle, counters.
    typedef struct {
        logic [45:0] data;
        int          readyAt;
    } item_t;

    logic [15:0] mCare  [64];
    logic [15:0] mValue [64];
    logic [45:0] mOr    [64];
    logic [45:0] mPol;
    item_t       mq [$];
    logic        mErr;
    int          mCnt;
    int          mCnt2;
    int          cyc = 0;
    logic        expValid;
    logic        expInReady;

    function automatic logic [45:0] evalModel(input logic [15:0] vec);
        logic [45:0] r;
        bit          hit;
        r = '0;
        for (int j = 0; j < 46; j++) begin
            hit = 0;
            for (int t = 0; t < 64; t++) begin
                if ((((vec ^ mValue[t]) & mCare[t]) == 16'h0) && mOr[t][j]) hit = 1;
            end
            r[j] = hit ^ mPol[j];
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int t = 0; t < 64; t++) begin
                mCare[t] = '0; mValue[t] = '0; mOr[t] = '0;
            end
            mPol  = '0;
            mq.delete();
            mErr  = 1'b0;
            mCnt  = 0;
            mCnt2 = 16'hFFFE;
        end else begin
            expValid   = (mq.size() > 0) && (mq[0].readyAt <= cyc);
            expInReady = !cfg_we && ((mq.size() < 2) || (expValid && out_ready));
            checkOutput("out_valid_model", {63'd0, out_valid}, {63'd0, expValid});
            if (expValid) checkOutput("out_data_model", {18'd0, out_data}, {18'd0, mq[0].data});
            checkOutput("in_ready_model", {63'd0, in_ready}, {63'd0, expInReady});
            checkOutput("cfg_ready_model", {63'd0, cfg_ready}, {63'd0, (mq.size() == 0)});
            checkOutput("cfg_err_model", {63'd0, cfg_err}, {63'd0, mErr});
            checkOutput("eval_cnt_model", {48'd0, eval_cnt}, mCnt);
            checkOutput("eval_cnt_sat_model", {48'd0, eval_cnt2}, mCnt2);

            if (cfg_we && mq.size() == 0) begin
                case (cfg_sel)
                    2'd0:    mCare[cfg_addr]  = cfg_wdata[15:0];
                    2'd1:    mValue[cfg_addr] = cfg_wdata[15:0];
                    2'd2:    mOr[cfg_addr]    = cfg_wdata;
                    default: mPol             = cfg_wdata;
                endcase
            end
            if (cfg_we && mq.size() != 0) mErr = 1'b1;
            else if (cfg_err_clr)         mErr = 1'b0;
            if (expValid && out_ready) begin
                void'(mq.pop_front());
                if (mCnt < 16'hFFFF)  mCnt++;
                if (mCnt2 < 16'hFFFF) mCnt2++;
            end
            if (in_valid && expInReady) mq.push_back('{evalModel(in_data), cyc + 2});
        end
        cyc++;
    end

    task automatic applyStimulus(input logic v, input logic [15:0] d, input logic r);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic cfgWrite(input logic [1:0] sel, input logic [5:0] addr, input logic [45:0] wdata);
        cfg_we    = 1'b1;
        cfg_sel   = sel;
        cfg_addr  = addr;
        cfg_wdata = wdata;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    logic [15:0] vecs [4];
    logic [45:0] exps [4];
    logic [45:0] results [4];
    int          sent;
    int          got;
    logic        fireIn;
    logic        fireOut;

    initial begin
        rst_n = 1'b0; cfg_we = 1'b0; cfg_sel = '0; cfg_addr = '0; cfg_wdata = '0;
        cfg_err_clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        checkOutput("reset_out_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("reset_out_data", {18'd0, out_data}, 64'd0);
        checkOutput("reset_cfg_ready", {63'd0, cfg_ready}, 64'd1);
        checkOutput("reset_cnt_preset", {48'd0, eval_cnt2}, 64'hFFFE);

        // Unprogrammed planes: every output is its (zero) polarity.
        applyStimulus(1'b1, 16'h1234, 1'b1);
        applyStimulus(1'b0, 16'h0000, 1'b1);
        checkOutput("default_valid", {63'd0, out_valid}, 64'd1);
        checkOutput("default_data", {18'd0, out_data}, 64'd0);
        applyStimulus(1'b0, 16'h0000, 1'b1);
        checkOutput("default_cnt", {48'd0, eval_cnt}, 64'd1);

        cfgWrite(2'd0, 6'd0, 46'h0003);
        cfgWrite(2'd1, 6'd0, 46'h0001);
        cfgWrite(2'd2, 6'd0, 46'h0020);
        cfgWrite(2'd3, 6'd0, 46'h0001);
        applyStimulus(1'b1, 16'h0001, 1'b1);
        applyStimulus(1'b1, 16'h0003, 1'b1);
        checkOutput("prog_hit", {18'd0, out_data}, 64'h21);
        applyStimulus(1'b0, 16'h0000, 1'b1);
        checkOutput("prog_miss", {18'd0, out_data}, 64'h01);
        applyStimulus(1'b0, 16'h0000, 1'b1);

        // Backpressure: two accepts fill the pipe, then everything drains in order.
        vecs = '{16'h0001, 16'h0003, 16'h0005, 16'h0002};
        exps = '{46'h21, 46'h01, 46'h21, 46'h01};
        sent = 0;
        got  = 0;
        for (int c = 0; c < 6; c++) begin
            in_valid  = (sent < 4);
            in_data   = vecs[sent];
            out_ready = 1'b0;
            #1;
            fireIn = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (fireIn) sent++;
            if (c >= 1) checkOutput("stall_hold", {17'd0, out_valid, out_data}, {17'd0, 1'b1, 46'h21});
        end
        checkOutput("stall_accepts", sent, 64'd2);
        checkOutput("stall_in_ready", {63'd0, in_ready}, 64'd0);
        for (int g = 0; g < 20 && got < 4; g++) begin
            in_valid  = (sent < 4);
            in_data   = (sent < 4) ? vecs[sent] : 16'h0000;
            out_ready = 1'b1;
            #1;
            fireIn  = in_valid && in_ready;
            fireOut = out_valid && out_ready;
            if (fireOut) results[got] = out_data;
            @(posedge clk);
            #1;
            if (fireIn)  sent++;
            if (fireOut) got++;
        end
        checkOutput("stream_count", got, 64'd4);
        for (int k = 0; k < 4; k++) checkOutput("stream_order", {18'd0, results[k]}, {18'd0, exps[k]});
        in_valid = 1'b0;
        applyStimulus(1'b0, 16'h0000, 1'b1);
        checkOutput("sat_cnt", {48'd0, eval_cnt2}, 64'hFFFF);

        // Write while busy is dropped; error set beats a simultaneous clear.
        applyStimulus(1'b1, 16'h0000, 1'b1);
        cfg_err_clr = 1'b1;
        cfgWrite(2'd1, 6'd0, 46'h0002);
        cfg_err_clr = 1'b0;
        checkOutput("err_set", {63'd0, cfg_err}, 64'd1);
        applyStimulus(1'b0, 16'h0000, 1'b1);
        cfg_err_clr = 1'b1;
        applyStimulus(1'b0, 16'h0000, 1'b1);
        cfg_err_clr = 1'b0;
        checkOutput("err_clr", {63'd0, cfg_err}, 64'd0);
        applyStimulus(1'b1, 16'h0001, 1'b1);
        applyStimulus(1'b0, 16'h0000, 1'b1);
        checkOutput("err_cfg_kept", {18'd0, out_data}, 64'h21);
        applyStimulus(1'b0, 16'h0000, 1'b1);

        // Last term, care bits above N_IN discarded: constant-1 term driving the top output.
        cfgWrite(2'd0, 6'd63, 46'h3FFF_0000_0000);
        cfgWrite(2'd2, 6'd63, 46'h2000_0000_0000);
        applyStimulus(1'b1, 16'h0003, 1'b1);
        applyStimulus(1'b0, 16'h0000, 1'b1);
        checkOutput("boundary_term63", {18'd0, out_data}, 64'h2000_0000_0001);
        applyStimulus(1'b0, 16'h0000, 1'b1);

        // Reset with two vectors in flight.
        applyStimulus(1'b1, 16'h0001, 1'b0);
        applyStimulus(1'b1, 16'h0003, 1'b0);
        in_valid = 1'b0;
        checkOutput("pre_reset_valid", {63'd0, out_valid}, 64'd1);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("reset_drop_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("reset_drop_cnt", {48'd0, eval_cnt}, 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        applyStimulus(1'b1, 16'h0001, 1'b1);
        applyStimulus(1'b0, 16'h0000, 1'b1);
        checkOutput("post_reset_valid", {63'd0, out_valid}, 64'd1);
        checkOutput("post_reset_data", {18'd0, out_data}, 64'd0);
        applyStimulus(1'b0, 16'h0000, 1'b1);
        checkOutput("post_reset_sat", {48'd0, eval_cnt2}, 64'hFFFF);
        applyStimulus(1'b0, 16'h0000, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
